// File: rtl/sub8u_serial_inv.sv
// Bit-serial inverse of the 8-bit unsigned adder: B = SUM - A, LSB first over 9 cycles.
// Define SUB8U_DMR_EN to add a lockstep NAND-form borrow chain that raises fault on mismatch.
module sub8u_serial_inv (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] sum,
    input  logic [7:0] a,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] b,
    output logic       underflow,
    output logic       overrange,
    output logic       fault
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, so they never overlap.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state, state_next;
    logic [8:0] s_reg;
    logic [8:0] a_reg;
    logic [8:0] d_reg;
    logic       br;
    logic [3:0] cnt;
    logic       s_bit, x_bit, d_bit, br_next;
    logic       accept;

    always_comb begin
        s_bit   = s_reg[0];
        x_bit   = a_reg[0];
        d_bit   = s_bit ^ x_bit ^ br;
        br_next = (~s_bit & x_bit) | (~(s_bit ^ x_bit) & br);
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == 4'd8) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_reg <= '0;
            a_reg <= '0;
            d_reg <= '0;
            br    <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            s_reg <= sum;
            a_reg <= {1'b0, a};
            d_reg <= '0;
            br    <= 1'b0;
            cnt   <= '0;
        end else if (state == RUN) begin
            s_reg <= s_reg >> 1;
            a_reg <= a_reg >> 1;
            d_reg <= {d_bit, d_reg[8:1]};
            br    <= br_next;
            cnt   <= cnt + 4'd1;
        end
    end

    // D and br are frozen outside RUN, so results hold until the next acceptance clears them.
    assign b         = d_reg[7:0];
    assign underflow = br;
    assign overrange = d_reg[8] & ~br;

`ifdef SUB8U_DMR_EN
    logic br2, br2_next, d2_bit, err;

    always_comb begin
        d2_bit   = s_bit ^ x_bit ^ br2;
        br2_next = ~(~(~s_bit & x_bit) & ~(~(s_bit ^ x_bit) & br2));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br2 <= 1'b0;
            err <= 1'b0;
        end else if (accept) begin
            br2 <= 1'b0;
            err <= 1'b0;
        end else if (state == RUN) begin
            br2 <= br2_next;
            if ((d2_bit != d_bit) || (br2 != br)) err <= 1'b1;
        end
    end

    assign fault = err;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_sub8u_serial_inv.sv
// Bench for sub8u_serial_inv: directed corner transactions plus random ones checked
// against an arithmetic model of SUM - A.
module tb_sub8u_serial_inv;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] sum;
    logic [7:0] a;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] b;
    logic       underflow;
    logic       overrange;
    logic       fault;

    int errors = 0;
    int checks = 0;

    sub8u_serial_inv dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b         (b),
        .underflow (underflow),
        .overrange (overrange),
        .fault     (fault)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference model: plain integer subtraction
    function automatic logic [9:0] model(input logic [8:0] s, input logic [7:0] x);
        int diff;
        logic [7:0] rb;
        logic uf, ov;
        diff = int'(s) - int'(x);
        rb   = 8'(diff & 255);
        uf   = (diff < 0);
        ov   = (diff > 255);
        return {ov, uf, rb};
    endfunction

    // one transaction starting at a negedge with the block idle; hold = DONE cycles with out_ready low
    task automatic do_txn(input logic [8:0] s, input logic [7:0] x, input int hold);
        logic [9:0] exp;
        int n;
        exp = model(s, x);
        check("idle_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        sum       = s;
        a         = x;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        sum      = 9'($urandom_range(0, 511));
        a        = 8'($urandom_range(0, 255));
        check("run_in_ready", in_ready, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 9);
        check("b", b, exp[7:0]);
        check("underflow", underflow, exp[8]);
        check("overrange", overrange, exp[9]);
        check("fault", fault, 0);
        check("done_in_ready", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_b", b, exp[7:0]);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_in_ready", in_ready, 1);
        check("post_out_valid", out_valid, 0);
        check("post_b_held", b, exp[7:0]);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum       = '0;
        a         = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_b", b, 0);
        check("rst_flags", {underflow, overrange, fault}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_txn(9'd200, 8'd55, 0);
        do_txn(9'd510, 8'd255, 0);
        do_txn(9'd0, 8'd0, 0);
        do_txn(9'd10, 8'd20, 0);
        do_txn(9'd300, 8'd0, 0);
        do_txn(9'd100, 8'd1, 5);
        do_txn(9'd511, 8'd0, 1);
        do_txn(9'd0, 8'd255, 0);

        // reset at E4 aborts the transaction
        in_valid  = 1'b1;
        sum       = 9'd450;
        a         = 8'd17;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_outputs", {b, underflow, overrange, fault}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_valid", out_valid, 0);
        end

        for (int t = 0; t < 40; t++) begin
            do_txn(9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)), $urandom_range(0, 3));
        end

`ifdef SUB8U_DMR_EN
        begin
            logic inv;
            in_valid  = 1'b1;
            sum       = 9'd200;
            a         = 8'd55;
            out_ready = 1'b0;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            inv = ~dut.br2;
            force dut.br2 = inv;
            @(negedge clk);
            release dut.br2;
            while (!out_valid) @(negedge clk);
            check("dmr_fault", fault, 1);
            check("dmr_b", b, 145);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d checks expected completion", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sub8u_serial_inv.md
# sub8u_serial_inv

Bit-serial 8-bit unsigned inverse adder: recovers operand B from a 9-bit adder result SUM and operand A as B = SUM − A. It uses an LSB-first borrow chain over 9 cycles with valid/ready handshakes on both sides. It sits downstream of the 8-bit unsigned adder family as its consistency partner: a result that cannot come from two 8-bit operands is flagged. An optional duplicated chain adds fault detection.

## Interface
Parameters:
- none; widths fixed (A/B 8 bits, SUM 9 bits).

Ports:
- clk  input  1  rising-edge clock; one clock domain.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  SUM/A offered.
- in_ready  output  1  block can accept; high only in IDLE.
- sum  input  9  adder result O[8:0].
- a  input  8  operand A.
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts result.
- b  output  8  (SUM − A) mod 256.
- underflow  output  1  SUM < A.
- overrange  output  1  SUM − A > 255 and no underflow.
- fault  output  1  chain mismatch (macro only, else 0).

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch sum into a 9-bit shift register S and {1'b0,a} into a 9-bit register A. Clear borrow br, bit counter cnt (4 bits), result register D and sticky error. Go to RUN.
- RUN, one bit per cycle from the LSB, using s=S[0] and x=A[0]:
  - d = s^x^br
  - br' = (~s&x) | (~(s^x)&br)
  - D shifts right with d entering D[8]
  - S and A shift right
  - cnt++
  - When cnt==8 is processed (9th RUN cycle), go to DONE.
- DONE: out_valid=1 and outputs stable.
  - b=D[7:0], underflow=br, overrange=D[8]&~br.
  - On out_valid&out_ready, go to IDLE. Outputs keep their last values until the next acceptance.
- in_valid is ignored outside IDLE. sum and a are sampled only at acceptance.
- Arithmetic is modulo 2^9 internally. The exposed b is the low 8 bits.

## Timing
- Reset (rst_n low at any edge): state=IDLE, in_ready=1 after the edge. out_valid=0, b=0, underflow=0, overrange=0, fault=0. Internal registers are cleared.
- Reset during RUN or DONE aborts the transaction. The result is discarded and never presented.
- Accept at edge E0. RUN covers E1..E9. out_valid=1 after E9.
- Handshake at E10 with out_ready=1 returns to IDLE. in_ready=1 after E10, so the next accept is at E11 at the earliest (11-cycle minimum period).
- out_ready low: DONE holds indefinitely, outputs unchanged, in_ready=0.
- out_ready high before DONE has no effect.
- in_ready and out_valid are never high in the same cycle.

## Configuration
- SUB8U_DMR_EN defined:
  - A second borrow/difference chain runs in lockstep, with its own borrow register computed in NAND-only form: br2' = ~(~(~s&x) & ~(~(s^x)&br2)). Its own difference bit is compared with d every RUN cycle, and br2 is compared with br.
  - Any mismatch sets the sticky error, which drives fault=1 in DONE.
  - The primary chain still drives b, underflow and overrange.
- SUB8U_DMR_EN undefined: no second chain and no error register. fault is tied to 0.

## Test plan
- sum=200, a=55, out_ready=1 → out_valid after E9; b=145, underflow=0, overrange=0, fault=0; in_ready high after E10.
- sum=510, a=255 → b=255, flags 0. Then sum=0, a=0 → b=0, flags 0. The two transactions run back-to-back, 11 cycles apart.
- sum=10, a=20 → b=246, underflow=1, overrange=0.
- sum=300, a=0 → b=44, underflow=0, overrange=1.
- Accept sum=100, a=1, hold out_ready=0 for 5 cycles after out_valid → b=99 stable, in_ready=0, second in_valid ignored. Raise out_ready → IDLE next edge.
- Reset low at E4 of a transaction → IDLE and all outputs 0 after that edge, no out_valid. With SUB8U_DMR_EN, force br2 inverted for one RUN cycle → fault=1 with b still correct.
